// File: rtl/hls_txn_recorder_pkg.sv
// Shared types for the HLS transaction recorder: record layout, FSM states,
// default field width and a saturating increment helper.
package hls_mon_pkg;

    localparam int TS_W_DEF = 32;

    // One completed (or flushed) HLS block-level transaction.
    typedef struct packed {
        logic [TS_W_DEF-1:0] start_ts;
        logic [TS_W_DEF-1:0] latency;
        logic [TS_W_DEF-1:0] ii;
        logic [TS_W_DEF-1:0] stall;
        logic                ready_seen;
        logic                incomplete;
    } txn_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE_WAIT,
        FROZEN
    } rec_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [TS_W_DEF-1:0] sat_inc(input logic [TS_W_DEF-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hls_txn_recorder_if.sv
// Observed ap_* handshake plus the valid/ready record stream toward the dumper.
// slave = recorder side, master = environment side (monitored block + consumer).
interface hls_txn_recorder_if;
    import hls_mon_pkg::*;

    logic     ap_start;
    logic     ap_ready;
    logic     ap_done;
    logic     ap_continue;
    logic     out_valid;
    logic     out_ready;
    txn_rec_t out_rec;

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, out_ready,
        output out_valid, out_rec
    );

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, out_ready,
        input  out_valid, out_rec
    );

endinterface

// File: rtl/hls_txn_recorder_fifo.sv
// Synchronous record FIFO, not fall-through. Pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
// A push while full is accepted only if a pop happens on the same edge.
module mon_rec_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_wdata,
    input  logic i_pop,
    output T     o_rdata,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    T           r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr_en;
    logic        w_rd_en;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);

    // Head is forced to zero when empty so the output is defined out of reset.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Storage write; no reset needed since the head is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointer update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/hls_txn_recorder.sv
// HLS transaction recorder: timestamps each ap_start..ap_done/ap_continue
// transaction against a free-running counter and queues a record per
// transaction for the CSV dumper. CNT_INIT only moves the counter's reset
// value (0 in normal use).
module hls_txn_recorder
    import hls_mon_pkg::*;
#(
    parameter int              TS_W     = TS_W_DEF,
    parameter int              DEPTH    = 8,
    parameter logic [TS_W-1:0] CNT_INIT = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish,
    hls_txn_recorder_if.slave bus,
    output logic              busy,
    output logic [TS_W-1:0]   txn_count,
    output logic              overflow
);

    rec_state_e      r_state, w_state_nxt;
    logic [TS_W-1:0] r_cnt;
    logic [TS_W-1:0] r_start_ts, w_start_ts_nxt;
    logic [TS_W-1:0] r_prev_start, w_prev_start_nxt;
    logic [TS_W-1:0] r_ii, w_ii_nxt;
    logic [TS_W-1:0] r_stall, w_stall_nxt;
    logic            r_first_flag, w_first_flag_nxt;
    logic            r_ready_seen, w_ready_seen_nxt;
    logic            w_ready_acc;
    logic            w_push;
    txn_rec_t        w_push_rec;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;

    assign busy          = (r_state != IDLE);
    assign bus.out_valid = !w_empty;
    assign w_pop         = bus.out_ready && !w_empty;
    assign w_ready_acc   = r_ready_seen | bus.ap_ready;

    // Free-running counter and FSM/record-context registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= CNT_INIT;
            r_start_ts   <= '0;
            r_prev_start <= '0;
            r_ii         <= '0;
            r_stall      <= '0;
            r_first_flag <= 1'b1;
            r_ready_seen <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= r_cnt + 1'b1;
            r_start_ts   <= w_start_ts_nxt;
            r_prev_start <= w_prev_start_nxt;
            r_ii         <= w_ii_nxt;
            r_stall      <= w_stall_nxt;
            r_first_flag <= w_first_flag_nxt;
            r_ready_seen <= w_ready_seen_nxt;
        end
    end

    // Next-state, record assembly and push decision.
    always_comb begin
        w_state_nxt      = r_state;
        w_start_ts_nxt   = r_start_ts;
        w_prev_start_nxt = r_prev_start;
        w_ii_nxt         = r_ii;
        w_stall_nxt      = r_stall;
        w_first_flag_nxt = r_first_flag;
        w_ready_seen_nxt = r_ready_seen;
        w_push           = 1'b0;
        w_push_rec       = '0;

        case (r_state)
            IDLE: begin
                if (finish) begin
                    w_state_nxt = FROZEN;
                end else if (bus.ap_start) begin
                    w_start_ts_nxt   = r_cnt;
                    w_ii_nxt         = r_first_flag ? '0 : r_cnt - r_prev_start;
                    w_prev_start_nxt = r_cnt;
                    w_first_flag_nxt = 1'b0;
                    w_stall_nxt      = '0;
                    w_ready_seen_nxt = bus.ap_ready;
                    if (bus.ap_done && bus.ap_continue) begin
                        w_push                = 1'b1;
                        w_push_rec.start_ts   = r_cnt;
                        w_push_rec.latency    = '0;
                        w_push_rec.ii         = w_ii_nxt;
                        w_push_rec.stall      = '0;
                        w_push_rec.ready_seen = bus.ap_ready;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end

            RUN: begin
                w_ready_seen_nxt = w_ready_acc;
                if (finish || (bus.ap_done && bus.ap_continue)) begin
                    w_push                = 1'b1;
                    w_push_rec.start_ts   = r_start_ts;
                    w_push_rec.latency    = r_cnt - r_start_ts;
                    w_push_rec.ii         = r_ii;
                    w_push_rec.stall      = r_stall;
                    w_push_rec.ready_seen = w_ready_acc;
                    w_push_rec.incomplete = finish;
                    w_state_nxt           = finish ? FROZEN : IDLE;
                end else if (bus.ap_done) begin
                    w_stall_nxt = {{(TS_W-1){1'b0}}, 1'b1};
                    w_state_nxt = DONE_WAIT;
                end
            end

            // ready_seen is frozen at the done cycle; only the stall keeps counting.
            DONE_WAIT: begin
                if (finish || bus.ap_continue) begin
                    w_push                = 1'b1;
                    w_push_rec.start_ts   = r_start_ts;
                    w_push_rec.latency    = r_cnt - r_start_ts;
                    w_push_rec.ii         = r_ii;
                    w_push_rec.stall      = r_stall;
                    w_push_rec.ready_seen = r_ready_seen;
                    w_push_rec.incomplete = finish;
                    w_state_nxt           = finish ? FROZEN : IDLE;
                end else begin
                    w_stall_nxt = sat_inc(r_stall);
                end
            end

            FROZEN: begin
                w_state_nxt = FROZEN;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Every push attempt counts; a push that finds the FIFO full with no pop is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            txn_count <= '0;
            overflow  <= 1'b0;
        end else if (w_push) begin
            txn_count <= txn_count + 1'b1;
            if (w_full && !w_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    mon_rec_fifo #(
        .T     (txn_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_push  (w_push),
        .i_wdata (w_push_rec),
        .i_pop   (bus.out_ready),
        .o_rdata (bus.out_rec),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_hls_txn_recorder.sv
// Directed bench for hls_txn_recorder. Inputs change on the falling edge and
// outputs are sampled on the falling edge after the rising edge of interest.
// `cur` is the counter value the DUT holds at the next rising edge.
module tb_hls_txn_recorder;
    import hls_mon_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        finish;
    logic        busy1, busy2, overflow1, overflow2;
    logic [31:0] txn_count1, txn_count2;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cur     = 0;
    txn_rec_t    exp;

    hls_txn_recorder_if bus1();
    hls_txn_recorder_if bus2();

    always #5 clock = ~clock;

    hls_txn_recorder #(.TS_W(32), .DEPTH(8)) dut1 (
        .clock(clock), .reset(reset), .finish(finish), .bus(bus1),
        .busy(busy1), .txn_count(txn_count1), .overflow(overflow1)
    );

    hls_txn_recorder #(.TS_W(32), .DEPTH(8), .CNT_INIT(32'hFFFF_FFF0)) dut2 (
        .clock(clock), .reset(reset), .finish(finish), .bus(bus2),
        .busy(busy2), .txn_count(txn_count2), .overflow(overflow2)
    );

    task automatic step();
        @(posedge clock);
        cur++;
        @(negedge clock);
    endtask

    task automatic goto(input int unsigned k);
        while (cur < k) step();
    endtask

    task automatic do_reset();
        finish = 0;
        bus1.ap_start = 0; bus1.ap_ready = 0; bus1.ap_done = 0; bus1.ap_continue = 1; bus1.out_ready = 0;
        bus2.ap_start = 0; bus2.ap_ready = 0; bus2.ap_done = 0; bus2.ap_continue = 1; bus2.out_ready = 0;
        reset = 1;
        @(posedge clock); @(posedge clock); @(negedge clock);
        reset = 0;
        cur = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus1.out_valid); end
        n_tests++; if (bus1.out_rec !== '0) begin n_fail++; $display("FAIL reset_out_rec got %h want 0", bus1.out_rec); end
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy1); end
        n_tests++; if (txn_count1 !== 32'd0) begin n_fail++; $display("FAIL reset_txn_count got %0d want 0", txn_count1); end
        n_tests++; if (overflow1 !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow1); end
    endtask

    task automatic test_single();
        do_reset();
        goto(10); bus1.ap_start = 1; step(); bus1.ap_start = 0;
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL single_busy_run got %0b want 1", busy1); end
        n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_early_rec got %0b want 0", bus1.out_valid); end
        goto(25); bus1.ap_done = 1; step(); bus1.ap_done = 0;
        exp = '{start_ts: 32'd10, latency: 32'd15, ii: 32'd0, stall: 32'd0, ready_seen: 1'b0, incomplete: 1'b0};
        n_tests++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", bus1.out_valid); end
        n_tests++; if (bus1.out_rec !== exp) begin n_fail++; $display("FAIL single_rec got %h want %h", bus1.out_rec, exp); end
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle got %0b want 0", busy1); end
        n_tests++; if (txn_count1 !== 32'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", txn_count1); end
        bus1.out_ready = 1; step(); bus1.out_ready = 0;
        n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %0b want 0", bus1.out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        goto(10); bus1.ap_start = 1; step(); bus1.ap_start = 0;
        goto(15); bus1.ap_done = 1; step(); bus1.ap_done = 0;
        goto(30); bus1.ap_start = 1; step(); bus1.ap_start = 0;
        goto(32); bus1.ap_ready = 1; step(); bus1.ap_ready = 0;
        goto(35); bus1.ap_done = 1; step(); bus1.ap_done = 0;
        n_tests++; if (txn_count1 !== 32'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", txn_count1); end
        exp = '{start_ts: 32'd10, latency: 32'd5, ii: 32'd0, stall: 32'd0, ready_seen: 1'b0, incomplete: 1'b0};
        n_tests++; if (bus1.out_rec !== exp) begin n_fail++; $display("FAIL b2b_rec0 got %h want %h", bus1.out_rec, exp); end
        bus1.out_ready = 1; step(); bus1.out_ready = 0;
        exp = '{start_ts: 32'd30, latency: 32'd5, ii: 32'd20, stall: 32'd0, ready_seen: 1'b1, incomplete: 1'b0};
        n_tests++; if (bus1.out_rec !== exp) begin n_fail++; $display("FAIL b2b_rec1 got %h want %h", bus1.out_rec, exp); end
    endtask

    task automatic test_stall();
        do_reset();
        goto(10); bus1.ap_start = 1; step(); bus1.ap_start = 0;
        goto(20); bus1.ap_done = 1; bus1.ap_continue = 0;
        step(); step(); step(); step();
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL stall_busy_wait got %0b want 1", busy1); end
        n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_rec got %0b want 0", bus1.out_valid); end
        bus1.ap_continue = 1; step(); bus1.ap_done = 0;
        exp = '{start_ts: 32'd10, latency: 32'd14, ii: 32'd0, stall: 32'd4, ready_seen: 1'b0, incomplete: 1'b0};
        n_tests++; if (bus1.out_rec !== exp) begin n_fail++; $display("FAIL stall_rec got %h want %h", bus1.out_rec, exp); end
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL stall_busy_done got %0b want 0", busy1); end
    endtask

    task automatic test_overflow();
        int unsigned want;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            goto(10 + 3 * k);
            bus1.ap_start = 1; bus1.ap_done = 1; step(); bus1.ap_start = 0; bus1.ap_done = 0;
            if (k == 7) begin
                n_tests++; if (overflow1 !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full got %0b want 0", overflow1); end
            end
        end
        n_tests++; if (overflow1 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0b want 1", overflow1); end
        n_tests++; if (txn_count1 !== 32'd10) begin n_fail++; $display("FAIL ovf_count got %0d want 10", txn_count1); end
        n_tests++; if (bus1.out_rec.start_ts !== 32'd10) begin n_fail++; $display("FAIL ovf_head got %0d want 10", bus1.out_rec.start_ts); end
        // Push and pop on the same edge while full: both must take effect.
        goto(40);
        bus1.ap_start = 1; bus1.ap_done = 1; bus1.out_ready = 1; step();
        bus1.ap_start = 0; bus1.ap_done = 0; bus1.out_ready = 0;
        n_tests++; if (txn_count1 !== 32'd11) begin n_fail++; $display("FAIL ovf_pushpop_count got %0d want 11", txn_count1); end
        for (int i = 0; i < 8; i++) begin
            want = (i < 7) ? 13 + 3 * i : 40;
            n_tests++; if (bus1.out_valid !== 1'b1 || bus1.out_rec.start_ts !== want) begin
                n_fail++; $display("FAIL ovf_drain%0d got v=%0b ts=%0d want v=1 ts=%0d", i, bus1.out_valid, bus1.out_rec.start_ts, want);
            end
            bus1.out_ready = 1; step(); bus1.out_ready = 0;
        end
        n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %0b want 0", bus1.out_valid); end
    endtask

    task automatic test_finish();
        do_reset();
        goto(40); bus1.ap_start = 1; step(); bus1.ap_start = 0;
        goto(50); finish = 1; step(); finish = 0;
        exp = '{start_ts: 32'd40, latency: 32'd10, ii: 32'd0, stall: 32'd0, ready_seen: 1'b0, incomplete: 1'b1};
        n_tests++; if (bus1.out_rec !== exp) begin n_fail++; $display("FAIL finish_rec got %h want %h", bus1.out_rec, exp); end
        goto(60); bus1.ap_start = 1; bus1.ap_done = 1; step(); bus1.ap_start = 0; bus1.ap_done = 0;
        step();
        n_tests++; if (txn_count1 !== 32'd1) begin n_fail++; $display("FAIL finish_frozen_count got %0d want 1", txn_count1); end
        n_tests++; if (bus1.out_rec !== exp) begin n_fail++; $display("FAIL finish_head_stable got %h want %h", bus1.out_rec, exp); end
        bus1.out_ready = 1; step(); bus1.out_ready = 0;
        n_tests++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL finish_drained got %0b want 0", bus1.out_valid); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        // dut2 counter = 0xFFFF_FFF0 + cur
        goto(13); bus2.ap_start = 1; step(); bus2.ap_start = 0;
        goto(18); bus2.ap_done = 1; step(); bus2.ap_done = 0;
        exp = '{start_ts: 32'hFFFF_FFFD, latency: 32'd5, ii: 32'd0, stall: 32'd0, ready_seen: 1'b0, incomplete: 1'b0};
        n_tests++; if (bus2.out_rec !== exp) begin n_fail++; $display("FAIL wrap_rec got %h want %h", bus2.out_rec, exp); end
        bus2.out_ready = 1; step(); bus2.out_ready = 0;
        goto(25); bus2.ap_start = 1; step(); bus2.ap_start = 0;
        goto(28);
        n_tests++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL wrap_busy_run got %0b want 1", busy2); end
        reset = 1; step(); reset = 0; cur = 0;
        n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %0b want 0", busy2); end
        step(); step(); step();
        n_tests++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %0b want 0", bus2.out_valid); end
        n_tests++; if (txn_count2 !== 32'd0) begin n_fail++; $display("FAIL midreset_count got %0d want 0", txn_count2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_finish();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
